fetch_decode_control: RTL and testbench
=======================================

FETCH_DECODE_CONTROL -- requirements
Module: fetch_decode_control

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port IROut  input  16  instruction from instruction register; fields [15:10] opcode, [8:6] DST, [5:3] SRC1, [2:0] SRC2, [7:0] ADDR.
REQ-004 SHALL have port Flags  input  4  ALU flags {Z,C,N,O}; bit 3 is Z.
REQ-005 SHALL have port RF_RegSel  output  4  register-file load enables, bit3=R1 .. bit0=R4, 1=enable.
REQ-006 SHALL have port RF_FunSel  output  3  register-file function; 010=load.
REQ-007 SHALL have ports RF_OutASel, RF_OutBSel  output  3 each  register-file read selects; 1xx selects R1..R4.
REQ-008 SHALL have port ALU_FunSel  output  5  ALU op: 10000 pass A, 10100 ADD, 10110 SUB, 10111 AND, 11000 ORR.
REQ-009 SHALL have ports MuxASel, MuxBSel, MuxCSel  output  2 each; MuxDSel  output  1  datapath mux selects.
REQ-010 SHALL have ports IR_Write, IR_LH  output  1 each  IR load enable; LH 0=low byte, 1=high byte.
REQ-011 SHALL have ports DR_E  output  1; DR_FunSel  output  2  data-register enable/function; 01=load.
REQ-012 SHALL have ports ARF_RegSel  output  3 (bit2=PC, bit1=SP, bit0=AR); ARF_FunSel  output  2 (00 dec, 01 inc, 10 load, 11 clear); ARF_OutDSel  output  2 (00 PC, 01 SP, 10 AR).
REQ-013 SHALL have ports Mem_CS  output  1 (0=selected); Mem_WR  output  1 (0 read, 1 write).
REQ-014 SHALL have ports T  output  3  current sequence count; Halted  output  1  HALT state indicator.

Function
REQ-015 SHALL hold a 3-bit sequence counter T and a state {RUN, HALT}; all control outputs combinational from T, state, IROut, Flags.
REQ-016 SHALL, in idle/default, drive all enables inactive: RF_RegSel=0000, ARF_RegSel=000, IR_Write=0, DR_E=0, Mem_CS=1, Mem_WR=0, other selects 0.
REQ-017 SHALL in T0: ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01 (PC+1 on edge).
REQ-018 SHALL in T1: identical to T0 except IR_LH=1.
REQ-019 SHALL treat IROut as valid from T2; Flags sampled combinationally in T2.
REQ-020 SHALL decode in T2: 0x00 BRA: ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11 (PC<-ADDR); end.
REQ-021 SHALL: 0x01 BNE: BRA controls only if Z=0, else no writes; end.
REQ-022 SHALL: 0x02 ADD, 0x03 SUB, 0x04 AND, 0x05 ORR, 0x06 MOV: RF_OutASel=SRC1, RF_OutBSel=SRC2, MuxDSel=0, ALU_FunSel per REQ-008 (MOV=pass A), MuxASel=00, RF_FunSel=010, RF_RegSel one-hot of DST[1:0]; end.
REQ-023 SHALL: 0x07 STR: RF_OutASel=DST, MuxDSel=0, ALU_FunSel=10000, MuxCSel=00, ARF_OutDSel=10, Mem_CS=0, Mem_WR=1; end.
REQ-024 SHALL: 0x08 LDR: T2 ARF_OutDSel=10, Mem_CS=0, DR_E=1, DR_FunSel=01; T3 MuxASel=10, RF_FunSel=010, RF_RegSel one-hot of DST; end at T3.
REQ-025 SHALL: 0x3F HLT: enter HALT at end of T2; Halted=1; outputs idle; T frozen at 0 until reset.
REQ-026 SHALL, for any register field with bit2=0 in REQ-022/023/024, suppress all RF/memory writes and end the instruction at T2.
REQ-027 SHALL treat undefined opcodes as NOP ending at T2.
REQ-028 SHALL on "end" load T=0 at the next edge; otherwise T increments; T never exceeds 3.

Reset
REQ-029 SHALL, while reset_n=0, force T=0, state=RUN, Halted=0, and all outputs to REQ-016 idle values, irrespective of clock.
REQ-030 SHALL, on reset deassertion mid-instruction, restart at T0 fetch with no partial-instruction writes.

Verification
REQ-031 Reset release -> T=0, Mem_CS=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=01.
REQ-032 IROut=0x0005 (BRA 0x05) at T2 -> ARF_RegSel=100, ARF_FunSel=10, MuxBSel=11; next cycle T=0.
REQ-033 BNE with Flags=1000 -> no enables in T2; with Flags=0000 -> BRA controls.
REQ-034 ADD DST=100, SRC1=101, SRC2=110 -> RF_OutASel=101, RF_OutBSel=110, ALU_FunSel=10100, RF_RegSel=1000, RF_FunSel=010.
REQ-035 LDR DST=111 -> T2 DR_E=1, Mem_CS=0; T3 MuxASel=10, RF_RegSel=0001; then T=0.
REQ-036 HLT -> Halted=1, outputs idle for 10 cycles; reset_n pulse low mid-cycle -> immediate idle, then T0 fetch.

Source files
------------

// File: rtl/fetch_decode_control_if.sv
// Bundle between the fetch/decode control unit and the datapath it steers.
//   IROut, Flags  : instruction register contents and ALU flags {Z,C,N,O}
//   RF_*          : register-file load enables, function and read selects
//   ALU_FunSel    : ALU operation
//   Mux*Sel       : datapath multiplexer selects
//   IR_Write/IR_LH: instruction-register load enable and byte select
//   DR_*, ARF_*   : data register and address register file controls
//   Mem_CS/Mem_WR : memory chip select (active low) and write strobe
//   T, Halted     : current sequence count and halt indicator
// master = control unit, slave = datapath.
interface fetch_decode_control_if;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [3:0]  RF_RegSel;
  logic [2:0]  RF_FunSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [4:0]  ALU_FunSel;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic [1:0]  MuxCSel;
  logic        MuxDSel;
  logic        IR_Write;
  logic        IR_LH;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic [2:0]  ARF_RegSel;
  logic [1:0]  ARF_FunSel;
  logic [1:0]  ARF_OutDSel;
  logic        Mem_CS;
  logic        Mem_WR;
  logic [2:0]  T;
  logic        Halted;

  modport master (
    input  IROut, Flags,
    output RF_RegSel, RF_FunSel, RF_OutASel, RF_OutBSel, ALU_FunSel,
           MuxASel, MuxBSel, MuxCSel, MuxDSel, IR_Write, IR_LH,
           DR_E, DR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel,
           Mem_CS, Mem_WR, T, Halted
  );

  modport slave (
    output IROut, Flags,
    input  RF_RegSel, RF_FunSel, RF_OutASel, RF_OutBSel, ALU_FunSel,
           MuxASel, MuxBSel, MuxCSel, MuxDSel, IR_Write, IR_LH,
           DR_E, DR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel,
           Mem_CS, Mem_WR, T, Halted
  );
endinterface

// File: rtl/fetch_decode_control.sv
// Fetch/decode control unit for a small 16-bit CPU.
//   clock   : rising-edge clock for T and run/halt state
//   reset_n : asynchronous active-low reset; also forces all controls idle
//   bus     : control bundle (IROut/Flags in, datapath controls, T, Halted out)
// T0/T1 fetch the low/high instruction byte (PC incremented each time),
// T2 executes, T3 is used only by LDR to write the loaded data back.
// All controls are combinational from T, run/halt state, IROut and Flags.
module fetch_decode_control (
  input logic                      clock,
  input logic                      reset_n,
  fetch_decode_control_if.master   bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_ADD = 6'h02;
  localparam logic [5:0] OP_SUB = 6'h03;
  localparam logic [5:0] OP_AND = 6'h04;
  localparam logic [5:0] OP_ORR = 6'h05;
  localparam logic [5:0] OP_MOV = 6'h06;
  localparam logic [5:0] OP_STR = 6'h07;
  localparam logic [5:0] OP_LDR = 6'h08;
  localparam logic [5:0] OP_HLT = 6'h3F;

  state_e      state_q, state_d;
  logic [2:0]  t_q, t_d;
  logic        end_instr;

  logic [5:0]  opcode;
  logic [2:0]  dst, src1, src2;
  logic        flag_z;
  logic        unused_ok;

  assign opcode    = bus.IROut[15:10];
  assign dst       = bus.IROut[8:6];
  assign src1      = bus.IROut[5:3];
  assign src2      = bus.IROut[2:0];
  assign flag_z    = bus.Flags[3];
  assign unused_ok = ^{bus.IROut[9], bus.Flags[2:0]};

  // Register fields name R1..R4 only when bit2 is set; DST[1:0]=00 -> R1 -> bit3.
  function automatic logic [3:0] rf_onehot(input logic [1:0] sel);
    return 4'b1000 >> sel;
  endfunction

  always_comb begin
    bus.RF_RegSel   = '0;
    bus.RF_FunSel   = '0;
    bus.RF_OutASel  = '0;
    bus.RF_OutBSel  = '0;
    bus.ALU_FunSel  = '0;
    bus.MuxASel     = '0;
    bus.MuxBSel     = '0;
    bus.MuxCSel     = '0;
    bus.MuxDSel     = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.IR_LH       = 1'b0;
    bus.DR_E        = 1'b0;
    bus.DR_FunSel   = '0;
    bus.ARF_RegSel  = '0;
    bus.ARF_FunSel  = '0;
    bus.ARF_OutDSel = '0;
    bus.Mem_CS      = 1'b1;
    bus.Mem_WR      = 1'b0;
    bus.T           = t_q;
    bus.Halted      = (state_q == ST_HALT);
    t_d             = t_q + 3'd1;
    state_d         = state_q;
    end_instr       = 1'b0;

    // Reset gates the decode so that no enable is asserted while reset_n is low.
    if (!reset_n) begin
      t_d     = '0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      t_d = '0;
    end else begin
      case (t_q)
        3'd0, 3'd1: begin
          bus.ARF_OutDSel = 2'b00;
          bus.Mem_CS      = 1'b0;
          bus.Mem_WR      = 1'b0;
          bus.IR_Write    = 1'b1;
          bus.IR_LH       = t_q[0];
          bus.ARF_RegSel  = 3'b100;
          bus.ARF_FunSel  = 2'b01;
        end
        3'd2: begin
          end_instr = 1'b1;
          case (opcode)
            OP_BRA, OP_BNE: begin
              if (opcode == OP_BRA || !flag_z) begin
                bus.ARF_RegSel = 3'b100;
                bus.ARF_FunSel = 2'b10;
                bus.MuxBSel    = 2'b11;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MOV: begin
              if (dst[2] && src1[2] && src2[2]) begin
                bus.RF_OutASel = src1;
                bus.RF_OutBSel = src2;
                bus.MuxDSel    = 1'b0;
                bus.MuxASel    = 2'b00;
                bus.RF_FunSel  = 3'b010;
                bus.RF_RegSel  = rf_onehot(dst[1:0]);
                case (opcode)
                  OP_ADD:  bus.ALU_FunSel = 5'b10100;
                  OP_SUB:  bus.ALU_FunSel = 5'b10110;
                  OP_AND:  bus.ALU_FunSel = 5'b10111;
                  OP_ORR:  bus.ALU_FunSel = 5'b11000;
                  default: bus.ALU_FunSel = 5'b10000;
                endcase
              end
            end
            OP_STR: begin
              if (dst[2]) begin
                bus.RF_OutASel  = dst;
                bus.MuxDSel     = 1'b0;
                bus.ALU_FunSel  = 5'b10000;
                bus.MuxCSel     = 2'b00;
                bus.ARF_OutDSel = 2'b10;
                bus.Mem_CS      = 1'b0;
                bus.Mem_WR      = 1'b1;
              end
            end
            OP_LDR: begin
              if (dst[2]) begin
                bus.ARF_OutDSel = 2'b10;
                bus.Mem_CS      = 1'b0;
                bus.DR_E        = 1'b1;
                bus.DR_FunSel   = 2'b01;
                end_instr       = 1'b0;
              end
            end
            OP_HLT: state_d = ST_HALT;
            default: ;
          endcase
        end
        3'd3: begin
          end_instr = 1'b1;
          if (opcode == OP_LDR && dst[2]) begin
            bus.MuxASel   = 2'b10;
            bus.RF_FunSel = 3'b010;
            bus.RF_RegSel = rf_onehot(dst[1:0]);
          end
        end
        default: end_instr = 1'b1;
      endcase
      if (end_instr) t_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_q     <= '0;
      state_q <= ST_RUN;
    end else begin
      t_q     <= t_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_control.sv
module tb_fetch_decode_control;

  typedef struct packed {
    logic [3:0] rf_regsel;
    logic [2:0] rf_funsel;
    logic [2:0] outa;
    logic [2:0] outb;
    logic [4:0] alu;
    logic [1:0] muxa;
    logic [1:0] muxb;
    logic [1:0] muxc;
    logic       muxd;
    logic       ir_write;
    logic       ir_lh;
    logic       dr_e;
    logic [1:0] dr_funsel;
    logic [2:0] arf_regsel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_outdsel;
    logic       mem_cs;
    logic       mem_wr;
    logic [2:0] t;
    logic       halted;
  } ctl_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic release_next = 1'b0;
  int   checks = 0;
  int   failures = 0;
  ctl_t  exp_q[$];
  string name_q[$];

  fetch_decode_control_if bus();

  fetch_decode_control dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic ctl_t actual();
    ctl_t a;
    a.rf_regsel   = bus.RF_RegSel;
    a.rf_funsel   = bus.RF_FunSel;
    a.outa        = bus.RF_OutASel;
    a.outb        = bus.RF_OutBSel;
    a.alu         = bus.ALU_FunSel;
    a.muxa        = bus.MuxASel;
    a.muxb        = bus.MuxBSel;
    a.muxc        = bus.MuxCSel;
    a.muxd        = bus.MuxDSel;
    a.ir_write    = bus.IR_Write;
    a.ir_lh       = bus.IR_LH;
    a.dr_e        = bus.DR_E;
    a.dr_funsel   = bus.DR_FunSel;
    a.arf_regsel  = bus.ARF_RegSel;
    a.arf_funsel  = bus.ARF_FunSel;
    a.arf_outdsel = bus.ARF_OutDSel;
    a.mem_cs      = bus.Mem_CS;
    a.mem_wr      = bus.Mem_WR;
    a.t           = bus.T;
    a.halted      = bus.Halted;
    return a;
  endfunction

  function automatic ctl_t idle_c(input logic [2:0] t, input logic halted);
    ctl_t c = '0;
    c.mem_cs = 1'b1;
    c.t      = t;
    c.halted = halted;
    return c;
  endfunction

  function automatic ctl_t fetch_c(input logic [2:0] t);
    ctl_t c = idle_c(t, 1'b0);
    c.mem_cs     = 1'b0;
    c.ir_write   = 1'b1;
    c.ir_lh      = (t == 3'd1);
    c.arf_regsel = 3'b100;
    c.arf_funsel = 2'b01;
    return c;
  endfunction

  // Monitor: every falling edge, if an expectation is pending, compare it.
  initial begin
    ctl_t  e, a;
    string n;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = actual();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
      end
    end
  end

  task automatic cycle(input logic [15:0] ir, input logic [3:0] fl,
                       input ctl_t e, input string nm);
    @(posedge clock);
    #1;
    if (release_next) begin
      reset_n      = 1'b1;
      release_next = 1'b0;
    end
    bus.IROut = ir;
    bus.Flags = fl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Reset pulse in the middle of a clock-high phase; released just after the next edge.
  task automatic mid_reset(input logic [15:0] ir, input string nm);
    @(posedge clock);
    #1;
    bus.IROut = ir;
    #1;
    reset_n = 1'b0;
    exp_q.push_back(idle_c(3'd0, 1'b0));
    name_q.push_back(nm);
    release_next = 1'b1;
  endtask

  function automatic logic [15:0] mk(input logic [5:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, 1'b0, d, s1, s2};
  endfunction

  // Instruction-level reference: fetch twice, then the opcode's execute cycle(s).
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input string nm);
    logic [5:0] op;
    logic [2:0] d, s1, s2;
    ctl_t e;
    bit   ldr_wb;
    op = ir[15:10];
    d  = ir[8:6];
    s1 = ir[5:3];
    s2 = ir[2:0];
    ldr_wb = 0;
    cycle(16'($urandom), 4'($urandom), fetch_c(3'd0), {nm, ".t0"});
    cycle(16'($urandom), 4'($urandom), fetch_c(3'd1), {nm, ".t1"});
    e = idle_c(3'd2, 1'b0);
    if (op == 6'h00 || (op == 6'h01 && fl[3] == 1'b0)) begin
      e.arf_regsel = 3'b100;
      e.arf_funsel = 2'b10;
      e.muxb       = 2'b11;
    end else if (op >= 6'h02 && op <= 6'h06) begin
      if (d >= 3'd4 && s1 >= 3'd4 && s2 >= 3'd4) begin
        e.outa      = s1;
        e.outb      = s2;
        e.rf_funsel = 3'b010;
        e.rf_regsel = 4'(1 << (7 - d));
        case (op)
          6'h02:   e.alu = 5'b10100;
          6'h03:   e.alu = 5'b10110;
          6'h04:   e.alu = 5'b10111;
          6'h05:   e.alu = 5'b11000;
          default: e.alu = 5'b10000;
        endcase
      end
    end else if (op == 6'h07) begin
      if (d >= 3'd4) begin
        e.outa        = d;
        e.alu         = 5'b10000;
        e.arf_outdsel = 2'b10;
        e.mem_cs      = 1'b0;
        e.mem_wr      = 1'b1;
      end
    end else if (op == 6'h08) begin
      if (d >= 3'd4) begin
        e.arf_outdsel = 2'b10;
        e.mem_cs      = 1'b0;
        e.dr_e        = 1'b1;
        e.dr_funsel   = 2'b01;
        ldr_wb        = 1;
      end
    end
    cycle(ir, fl, e, {nm, ".t2"});
    if (ldr_wb) begin
      e = idle_c(3'd3, 1'b0);
      e.muxa      = 2'b10;
      e.rf_funsel = 3'b010;
      e.rf_regsel = 4'(1 << (7 - d));
      cycle(ir, 4'($urandom), e, {nm, ".t3"});
    end
    if (op == 6'h3F) begin
      for (int i = 0; i < 10; i++)
        cycle(16'($urandom), 4'($urandom), idle_c(3'd0, 1'b1), {nm, ".halted"});
    end
  endtask

  function automatic logic [2:0] rand_reg();
    if ($urandom_range(0, 4) == 0) return 3'($urandom_range(0, 3));
    return 3'($urandom_range(4, 7));
  endfunction

  initial begin
    logic [5:0] op;
    bus.IROut = '0;
    bus.Flags = '0;
    reset_n   = 1'b0;
    cycle(16'hFFFF, 4'hF, idle_c(3'd0, 1'b0), "reset_hold0");
    cycle(16'hFFFF, 4'hF, idle_c(3'd0, 1'b0), "reset_hold1");
    release_next = 1'b1;

    run_instr(16'h0005, 4'b0000, "bra_05");
    run_instr(mk(6'h01, 3'd0, 3'd5, 3'd1), 4'b1000, "bne_z1");
    run_instr(mk(6'h01, 3'd0, 3'd5, 3'd1), 4'b0000, "bne_z0");
    run_instr(mk(6'h02, 3'd4, 3'd5, 3'd6), 4'b0000, "add_456");
    run_instr(mk(6'h08, 3'd7, 3'd0, 3'd0), 4'b0000, "ldr_r4");
    run_instr(mk(6'h03, 3'd6, 3'd7, 3'd2), 4'b0000, "sub_badsrc2");
    run_instr(mk(6'h07, 3'd3, 3'd0, 3'd0), 4'b0000, "str_baddst");
    run_instr(mk(6'h07, 3'd5, 3'd0, 3'd0), 4'b0000, "str_r2");
    run_instr(mk(6'h08, 3'd1, 3'd0, 3'd0), 4'b0000, "ldr_baddst");
    run_instr(mk(6'h06, 3'd4, 3'd7, 3'd5), 4'b0000, "mov");
    run_instr(mk(6'h20, 3'd4, 3'd4, 3'd4), 4'b0000, "undef_20");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 11) <= 8) op = 6'($urandom_range(0, 8));
      else op = 6'($urandom_range(9, 62));
      run_instr(mk(op, rand_reg(), rand_reg(), rand_reg()) | 16'({$urandom_range(0, 1), 9'h0}),
                4'($urandom), "rand");
    end

    // Reset mid-LDR execute: no partial write, fetch restarts.
    cycle(16'h0, 4'h0, fetch_c(3'd0), "ldr_abort.t0");
    cycle(16'h0, 4'h0, fetch_c(3'd1), "ldr_abort.t1");
    mid_reset(mk(6'h08, 3'd6, 3'd0, 3'd0), "ldr_abort.reset");
    run_instr(mk(6'h05, 3'd5, 3'd6, 3'd7), 4'b0000, "orr_after_abort");

    run_instr(mk(6'h3F, 3'd0, 3'd0, 3'd0), 4'b0000, "hlt");
    mid_reset(16'h0005, "hlt.reset");
    run_instr(16'h0005, 4'b0000, "bra_after_halt");

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
